lr35902_oam_scan: RTL and testbench

- PPU mode-2 OAM scanner: the read-side counterpart to the OAM DMA engine, which writes OAM.
- On each line start, walks all 40 OAM entries, compares each object's Y against the current line, and latches up to 10 hits (X, OAM index, row within object) into an internal buffer.
- The sprite fetcher reads hits from that buffer during mode 3.
- Sits between the OAM RAM read port and the PPU pixel pipeline.

---
 rtl/lr35902_oam_scan.sv | 181 ++++++++++++++++++
 tb/tb_lr35902_oam_scan.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lr35902_oam_scan.sv
// lr35902_oam_scan
// PPU mode-2 OAM scanner. On each start pulse it walks all OAM entries,
// reading the Y byte then the X byte of each entry, and latches up to
// MAX_OBJ objects whose Y range covers the sampled line into a small hit
// buffer. The sprite fetcher reads that buffer during mode 3.
//
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   start            one-cycle pulse, begins (or restarts) a scan
//   ly, obj_size     line number and object height, sampled on start
//   dma_active       OAM DMA in progress
//   adr_oam, read    OAM read address/strobe; data returns on din next cycle
//   din              OAM read data
//   busy, done       scan in progress / one-cycle completion pulse
//   obj_count        number of valid hits in the buffer
//   obj_sel          buffer read index
//   obj_x, obj_idx, obj_row  combinational contents of buffer[obj_sel]
//
// Optional feature: define OAM_SCAN_DMA_BLOCK_EN to suppress OAM reads while
// dma_active is high and force entries evaluated during DMA to miss.
module lr35902_oam_scan #(
  parameter int MAX_OBJ = 10,
  parameter int NUM_ENT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ly,
  input  logic       obj_size,
  input  logic       dma_active,
  output logic [7:0] adr_oam,
  output logic       read,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [3:0] obj_count,
  input  logic [3:0] obj_sel,
  output logic [7:0] obj_x,
  output logic [5:0] obj_idx,
  output logic [3:0] obj_row
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [5:0] LAST_E = 6'(NUM_ENT - 1);
  localparam logic [3:0] CAP    = 4'(MAX_OBJ);

  logic [1:0] state_q, state_d;
  logic [5:0] e_q, e_d;
  logic       phase_q, phase_d;
  logic [7:0] ly_q, ly_d;
  logic       size_q, size_d;
  logic       hit_q, hit_d;
  logic [3:0] row_q, row_d;
  logic [5:0] hit_e_q, hit_e_d;
  logic [3:0] count_q, count_d;

  logic [7:0] buf_x_q   [MAX_OBJ];
  logic [5:0] buf_idx_q [MAX_OBJ];
  logic [3:0] buf_row_q [MAX_OBJ];

  logic       scanning;
  logic [7:0] diff;
  logic [7:0] lim;
  logic       y_hit;
  logic       store;
  logic       wr_en;

  assign scanning = (state_q == ST_SCAN);

  // Row offset into the object; wraps mod 256 so lines above the object
  // produce a large value and fail the height compare.
  assign diff = ly_q + 8'd16 - din;
  assign lim  = size_q ? 8'd16 : 8'd8;

`ifdef OAM_SCAN_DMA_BLOCK_EN
  // While DMA owns OAM the read data is meaningless, so the entry misses.
  assign y_hit = (diff < lim) && !dma_active;
  assign read  = scanning && !dma_active;
`else
  assign y_hit = (diff < lim);
  assign read  = scanning;
`endif

  // hit_q is only ever high for the cycle after a Y evaluation, which is
  // exactly the cycle din carries that entry's X byte.
  assign store = hit_q && (count_q < CAP);
  assign wr_en = store && !start;

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    phase_d = phase_q;
    ly_d    = ly_q;
    size_d  = size_q;
    hit_d   = 1'b0;
    row_d   = row_q;
    hit_e_d = hit_e_q;
    count_d = count_q;

    case (state_q)
      ST_SCAN: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          hit_d   = y_hit;
          row_d   = diff[3:0];
          hit_e_d = e_q;
          phase_d = 1'b0;
          if (e_q == LAST_E) begin
            state_d = ST_FLUSH;
          end else begin
            e_d = e_q + 6'd1;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (store) begin
      count_d = count_q + 4'd1;
    end

    // A start pulse always wins: it aborts any scan in flight.
    if (start) begin
      state_d = ST_SCAN;
      e_d     = 6'd0;
      phase_d = 1'b0;
      ly_d    = ly;
      size_d  = obj_size;
      hit_d   = 1'b0;
      count_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      e_q     <= 6'd0;
      phase_q <= 1'b0;
      ly_q    <= 8'd0;
      size_q  <= 1'b0;
      hit_q   <= 1'b0;
      row_q   <= 4'd0;
      hit_e_q <= 6'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      phase_q <= phase_d;
      ly_q    <= ly_d;
      size_q  <= size_d;
      hit_q   <= hit_d;
      row_q   <= row_d;
      hit_e_q <= hit_e_d;
      count_q <= count_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_x_q[count_q]   <= din;
      buf_idx_q[count_q] <= hit_e_q;
      buf_row_q[count_q] <= row_q;
    end
  end

  assign adr_oam   = scanning ? {e_q, 1'b0, phase_q} : 8'd0;
  assign busy      = (state_q != ST_IDLE);
  // A start landing on the flush cycle aborts that scan, so no done.
  assign done      = (state_q == ST_FLUSH) && !start;
  assign obj_count = count_q;
  assign obj_x     = buf_x_q[obj_sel];
  assign obj_idx   = buf_idx_q[obj_sel];
  assign obj_row   = buf_row_q[obj_sel];

endmodule

// File: tb/tb_lr35902_oam_scan.sv
// tb_lr35902_oam_scan
// Directed self-checking bench for lr35902_oam_scan. A behavioural OAM
// answers reads one cycle later. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_lr35902_oam_scan;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] ly;
  logic       obj_size;
  logic       dma_active;
  logic [7:0] adr_oam;
  logic       read;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [3:0] obj_count;
  logic [3:0] obj_sel;
  logic [7:0] obj_x;
  logic [5:0] obj_idx;
  logic [3:0] obj_row;

  int total;
  int bad;

  logic [7:0] oam [160];

  lr35902_oam_scan dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ly         (ly),
    .obj_size   (obj_size),
    .dma_active (dma_active),
    .adr_oam    (adr_oam),
    .read       (read),
    .din        (din),
    .busy       (busy),
    .done       (done),
    .obj_count  (obj_count),
    .obj_sel    (obj_sel),
    .obj_x      (obj_x),
    .obj_idx    (obj_idx),
    .obj_row    (obj_row)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // OAM model: synchronous read, data valid the cycle after the strobe
  always @(posedge clk) begin
    if (read) din <= oam[adr_oam];
  end

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) oam[i] = 8'd0;
  endtask

  // Every entry gets the same Y; X is xbase + index
  task automatic fill_oam(input logic [7:0] y, input logic [7:0] xbase);
    for (int i = 0; i < 40; i++) begin
      oam[4*i]   = y;
      oam[4*i+1] = xbase + 8'(i);
      oam[4*i+2] = 8'd0;
      oam[4*i+3] = 8'd0;
    end
  endtask

  // Start high for one cycle t; returns at the falling edge of cycle t+1
  task automatic pulse_start(input logic [7:0] l, input logic s);
    @(negedge clk);
    ly = l;
    obj_size = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done is seen; 200 means timed out
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Scan and land on the cycle after done, when the last store is visible
  task automatic run_scan(input logic [7:0] l, input logic s, input string name);
    int n;
    pulse_start(l, s);
    wait_done(n);
    total++;
    if (n !== 80) begin
      bad++;
      $display("[TB] FAIL %s done_latency got=%0d want=80", name, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    @(negedge clk);
    total++;
    if ({busy, done, read, adr_oam, obj_count} !== 15'd0) begin
      bad++;
      $display("[TB] FAIL reset_values got busy=%b done=%b read=%b adr=%0d cnt=%0d want all 0",
               busy, done, read, adr_oam, obj_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty_scan();
    logic [7:0] exp_adr;
    clear_oam();
    pulse_start(8'd5, 1'b0);
    for (int k = 0; k < 80; k++) begin
      exp_adr = 8'((k / 2) * 4 + (k % 2));
      total++;
      if (busy !== 1'b1 || read !== 1'b1 || done !== 1'b0 || adr_oam !== exp_adr) begin
        bad++;
        $display("[TB] FAIL empty_seq cyc=%0d got busy=%b read=%b done=%b adr=%0d want 1 1 0 adr=%0d",
                 k + 1, busy, read, done, adr_oam, exp_adr);
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || read !== 1'b0) begin
      bad++;
      $display("[TB] FAIL empty_flush got done=%b busy=%b read=%b want 1 1 0", done, busy, read);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || obj_count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL empty_end got done=%b busy=%b cnt=%0d want 0 0 0", done, busy, obj_count);
    end
  endtask

  task automatic test_hit_rows();
    logic [7:0] lys  [3];
    logic [3:0] cnts [3];
    logic [3:0] rows [3];
    lys[0] = 8'd5;  cnts[0] = 4'd1; rows[0] = 4'd0;
    lys[1] = 8'd12; cnts[1] = 4'd1; rows[1] = 4'd7;
    lys[2] = 8'd13; cnts[2] = 4'd0; rows[2] = 4'd0;
    clear_oam();
    oam[12] = 8'd21;
    oam[13] = 8'd40;
    obj_sel = 4'd0;
    for (int v = 0; v < 3; v++) begin
      run_scan(lys[v], 1'b0, "hit_rows");
      total++;
      if (obj_count !== cnts[v]) begin
        bad++;
        $display("[TB] FAIL hit_count ly=%0d got=%0d want=%0d", lys[v], obj_count, cnts[v]);
      end
      if (cnts[v] != 4'd0) begin
        total++;
        if (obj_x !== 8'd40 || obj_idx !== 6'd3 || obj_row !== rows[v]) begin
          bad++;
          $display("[TB] FAIL hit_entry ly=%0d got x=%0d idx=%0d row=%0d want x=40 idx=3 row=%0d",
                   lys[v], obj_x, obj_idx, obj_row, rows[v]);
        end
      end
    end
  endtask

  task automatic test_tall();
    clear_oam();
    oam[28] = 8'd16;
    oam[29] = 8'd55;
    obj_sel = 4'd0;
    run_scan(8'd15, 1'b1, "tall16");
    total++;
    if (obj_count !== 4'd1 || obj_idx !== 6'd7 || obj_row !== 4'd15 || obj_x !== 8'd55) begin
      bad++;
      $display("[TB] FAIL tall16 got cnt=%0d idx=%0d row=%0d x=%0d want 1 7 15 55",
               obj_count, obj_idx, obj_row, obj_x);
    end
    run_scan(8'd15, 1'b0, "tall8");
    total++;
    if (obj_count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL tall8 cnt got=%0d want=0", obj_count);
    end
  endtask

  task automatic test_saturation();
    fill_oam(8'd16, 8'd100);
    run_scan(8'd0, 1'b0, "saturate");
    total++;
    if (obj_count !== 4'd10) begin
      bad++;
      $display("[TB] FAIL sat_count got=%0d want=10", obj_count);
    end
    for (int i = 0; i < 10; i++) begin
      obj_sel = 4'(i);
      #1;
      total++;
      if (obj_idx !== 6'(i) || obj_x !== 8'(100 + i) || obj_row !== 4'd0) begin
        bad++;
        $display("[TB] FAIL sat_entry sel=%0d got idx=%0d x=%0d row=%0d want idx=%0d x=%0d row=0",
                 i, obj_idx, obj_x, obj_row, i, 100 + i);
      end
    end
    repeat (5) @(negedge clk);
    obj_sel = 4'd9;
    #1;
    total++;
    if (obj_count !== 4'd10 || obj_idx !== 6'd9 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_stable got cnt=%0d idx=%0d busy=%b want 10 9 0", obj_count, obj_idx, busy);
    end
  endtask

  task automatic test_restart();
    int n;
    int early;
    fill_oam(8'd16, 8'd100);
    early = 0;
    pulse_start(8'd0, 1'b0);
    for (int k = 1; k < 30; k++) begin
      if (done === 1'b1) early++;
      @(negedge clk);
    end
    ly = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    total++;
    if (n !== 80 || early !== 0) begin
      bad++;
      $display("[TB] FAIL restart_done got latency=%0d early=%0d want 80 0", n, early);
    end
    @(negedge clk);
    total++;
    if (obj_count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL restart_count got=%0d want=0", obj_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    int dones;
    fill_oam(8'd16, 8'd100);
    pulse_start(8'd0, 1'b0);
    repeat (39) @(negedge clk);
    total++;
    if (obj_count !== 4'd10 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset got cnt=%0d busy=%b want 10 1", obj_count, busy);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || obj_count !== 4'd0 || read !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset got busy=%b cnt=%0d read=%b want 0 0 0", busy, obj_count, read);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 100; k++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("[TB] FAIL post_reset_quiet activity cycles got=%0d want=0", dones);
    end
  endtask

  task automatic test_dma_block();
    int n;
    int reads;
    int exp_reads;
    logic [3:0] exp_cnt;
`ifdef OAM_SCAN_DMA_BLOCK_EN
    exp_reads = 0;
    exp_cnt   = 4'd0;
`else
    exp_reads = 80;
    exp_cnt   = 4'd10;
`endif
    fill_oam(8'd16, 8'd100);
    dma_active = 1'b1;
    reads = 0;
    pulse_start(8'd0, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (read === 1'b1) reads++;
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (n !== 80 || reads !== exp_reads || obj_count !== exp_cnt) begin
      bad++;
      $display("[TB] FAIL dma got latency=%0d reads=%0d cnt=%0d want 80 %0d %0d",
               n, reads, obj_count, exp_reads, exp_cnt);
    end
    dma_active = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    start      = 1'b0;
    ly         = 8'd0;
    obj_size   = 1'b0;
    dma_active = 1'b0;
    obj_sel    = 4'd0;
    din        = 8'd0;
    clear_oam();
    test_reset();
    test_empty_scan();
    test_hit_rows();
    test_tall();
    test_saturation();
    test_restart();
    test_reset_mid_scan();
    test_dma_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
